// File: rtl/uart_rx_engine.sv
// uart_rx_engine: UART receive front end (rx sync, start-bit check, mid-bit sampling, frame unpack).
// Latency: rx pin -> rx_s 2 cycles; start-bit sample k>>1 cycles after start rises; unpack on the done cycle.
// Backpressure: none; a frame completing while rxrdy is still set overwrites rx_data and raises ovf.
//
// Ports:
//   clk, reset     system clock, asynchronous active-low reset
//   rx             raw serial line (idle high), synchronised internally
//   k              bit time in clk cycles (4..2^KW-1), latched at start-bit detection
//   eight/pen/ohel frame format: 8 vs 7 data bits, parity enable, odd(1)/even(0) parity
//   done           frame-complete flag from the external bit counter
//   rx_read        CPU read strobe, clears rxrdy and ovf
//   start/do_it    start-bit validation / frame-in-progress, fed to the bit counter
//   btu            one-cycle pulse at every mid-bit sample point
//   rx_data, rxrdy, perr, ferr, ovf   CPU-side receive data and status
module uart_rx_engine #(
  parameter int KW = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic [KW-1:0] k,
  input  logic          eight,
  input  logic          pen,
  input  logic          ohel,
  input  logic          done,
  input  logic          rx_read,
  output logic          start,
  output logic          do_it,
  output logic          btu,
  output logic [7:0]    rx_data,
  output logic          rxrdy,
  output logic          perr,
  output logic          ferr,
  output logic          ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [KW-1:0] k_l_q, k_l_d;
  logic [KW-1:0] bt_q, bt_d;
  logic [KW-1:0] limit;
  logic [9:0]    sr_q, sr_d;
  logic          load;

  logic [1:0]    sh;
  logic [9:0]    a;
  logic [7:0]    f_data;
  logic          f_par;
  logic          f_stop;

  logic [7:0]    rx_data_q, rx_data_d;
  logic          rxrdy_q, rxrdy_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovf_q, ovf_d;

  // Two-flop synchroniser; resets to the idle (high) line level so a
  // reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign start = (state_q == ST_START);
  assign do_it = (state_q != ST_IDLE);

  // Half-bit limit during the start bit puts every later sample mid-bit.
  assign limit = start ? (k_l_q >> 1) : k_l_q;
  assign btu   = do_it & (bt_q == limit - KW'(1));

  always_comb begin
    bt_d = bt_q + KW'(1);
    if (!do_it || btu) begin
      bt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    k_l_d   = k_l_q;
    sr_d    = sr_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          k_l_d   = k;
          sr_d    = '0;
        end
      end
      ST_START: begin
        // Line back high at the start-bit centre: glitch, drop it silently.
        if (btu) begin
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (btu) begin
          sr_d = {rx_s_q, sr_q[9:1]};
        end
        if (done) begin
          state_d = ST_IDLE;
          load    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_l_q   <= '0;
      bt_q    <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      k_l_q   <= k_l_d;
      bt_q    <= bt_d;
      sr_q    <= sr_d;
    end
  end

  // Frame unpack. Shorter frames sit in the upper bits of sr, so shift
  // them down to bit 0 first; then all formats share one field layout
  // that only differs in where parity and stop fall.
  always_comb begin
    unique case ({eight, pen})
      2'b00:   sh = 2'd2;
      2'b01:   sh = 2'd1;
      default: sh = 2'd0;
    endcase
    a      = sr_q >> sh;
    f_data = a[7:0];
    f_par  = 1'b0;
    f_stop = a[9];
    unique case ({eight, pen})
      2'b11: begin
        f_data = a[7:0];
        f_par  = a[8];
        f_stop = a[9];
      end
      2'b10: begin
        // a[9] is the sample taken one bit past the stop bit.
        f_data = a[7:0];
        f_stop = a[8];
      end
      2'b01: begin
        f_data = {1'b0, a[6:0]};
        f_par  = a[7];
        f_stop = a[8];
      end
      default: begin
        f_data = {1'b0, a[6:0]};
        f_stop = a[7];
      end
    endcase
  end

  always_comb begin
    rx_data_d = rx_data_q;
    rxrdy_d   = rxrdy_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovf_d     = ovf_q;
    if (load) begin
      rx_data_d = f_data;
      perr_d    = pen & (((^f_data) ^ f_par) != ohel);
      ferr_d    = ~f_stop;
      // A read landing on the load cycle consumes the old byte, so no overrun.
      ovf_d     = ovf_q | (rxrdy_q & ~rx_read);
      rxrdy_d   = 1'b1;
    end else if (rx_read) begin
      rxrdy_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data_q <= '0;
      rxrdy_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rxrdy_q   <= rxrdy_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rxrdy   = rxrdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule
